// File: rtl/main_memory.sv
// Block-granular backing store for the cache's miss fills and write-backs.
// Accepts one request at a time, completes it after LATENCY cycles and
// signals completion with a single-cycle mem_ready pulse.
module main_memory #(
    parameter int unsigned PA_WIDTH   = 32,
    parameter int unsigned BLK_WIDTH  = 512,
    parameter int unsigned MEM_BLOCKS = 1024,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PA_WIDTH-1:0]  mem_addr,
    input  logic                 mem_rd_en,
    input  logic                 mem_wr_en,
    input  logic [BLK_WIDTH-1:0] mem_wr_blk,
    output logic [BLK_WIDTH-1:0] mem_rd_blk,
    output logic                 mem_ready,
    output logic                 mem_busy
);

    localparam int unsigned OFF_W = $clog2(BLK_WIDTH / 8);
    localparam int unsigned IDX_W = $clog2(MEM_BLOCKS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Latched request: write flag, block index and write payload
    typedef struct packed {
        logic                 wr;
        logic [IDX_W-1:0]     idx;
        logic [BLK_WIDTH-1:0] data;
    } req_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    req_t             r_req;
    req_t             w_req_nxt;
    logic             w_complete;
    logic             w_busy_nxt;
    logic             w_ready_nxt;

    logic [BLK_WIDTH-1:0] r_mem [MEM_BLOCKS];

    // Offset and alias bits of the address carry no information here
    logic w_unused_addr;
    assign w_unused_addr = ^mem_addr;

    // Next-state, counter and request-latch logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_wr_en || mem_rd_en) begin
                    // A write wins over a simultaneous read; the read is dropped
                    w_req_nxt.wr   = mem_wr_en;
                    w_req_nxt.idx  = mem_addr[OFF_W +: IDX_W];
                    w_req_nxt.data = mem_wr_blk;
                    w_cnt_nxt      = CNT_W'(LATENCY - 1);
                    w_state_nxt    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_ready_nxt = (w_state_nxt == S_DONE);
    end

    // State, counter, latched request and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_req      <= '0;
            mem_rd_blk <= '0;
            mem_ready  <= 1'b0;
            mem_busy   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_req     <= w_req_nxt;
            mem_ready <= w_ready_nxt;
            mem_busy  <= w_busy_nxt;
            if (w_complete && !r_req.wr) begin
                mem_rd_blk <= r_mem[r_req.idx];
            end
        end
    end

    // Storage array; deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (w_complete && r_req.wr) begin
            r_mem[r_req.idx] <= r_req.data;
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: directed scenarios plus random traffic
// checked against an associative-array model of the block store.
module tb_main_memory;

    localparam int unsigned PA_WIDTH   = 32;
    localparam int unsigned BLK_WIDTH  = 512;
    localparam int unsigned MEM_BLOCKS = 1024;
    localparam int unsigned LATENCY    = 4;
    localparam int unsigned BLK_BYTES  = BLK_WIDTH / 8;

    typedef logic [BLK_WIDTH-1:0] blk_t;

    typedef struct {
        bit   is_rd;
        blk_t data;
        int   cyc;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [PA_WIDTH-1:0]  mem_addr;
    logic                 mem_rd_en;
    logic                 mem_wr_en;
    logic [BLK_WIDTH-1:0] mem_wr_blk;
    logic [BLK_WIDTH-1:0] mem_rd_blk;
    logic                 mem_ready;
    logic                 mem_busy;

    main_memory #(
        .PA_WIDTH  (PA_WIDTH),
        .BLK_WIDTH (BLK_WIDTH),
        .MEM_BLOCKS(MEM_BLOCKS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_wr_blk(mem_wr_blk),
        .mem_rd_blk(mem_rd_blk),
        .mem_ready (mem_ready),
        .mem_busy  (mem_busy)
    );

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    blk_t ref_mem[int];
    blk_t ref_rd = '0;
    bit   prev_ready = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < int'(BLK_WIDTH / 32); i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic int blk_of(logic [PA_WIDTH-1:0] addr);
        return int'((addr / BLK_BYTES) % MEM_BLOCKS);
    endfunction

    task automatic check_blk(string name, blk_t act, blk_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mem_ready) begin
            check_int("ready_width", int'(prev_ready), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready with empty scoreboard at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                check_int("ready_latency", cyc, e.cyc);
                if (e.is_rd) ref_rd = e.data;
                check_blk("rd_blk", mem_rd_blk, ref_rd);
            end
        end
        prev_ready = mem_ready && rst_n;
    end

    task automatic wait_idle();
        int n = 0;
        while (mem_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (mem_busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy stuck at 1, want 0");
        end
    endtask

    // Issue one request from a negedge; optionally pulse a stray write while busy
    task automatic issue(bit rd, bit wr, logic [PA_WIDTH-1:0] addr, blk_t data,
                         bit glitch, logic [PA_WIDTH-1:0] g_addr);
        exp_t e;
        int   idx;
        int   n;
        wait_idle();
        mem_addr   = addr;
        mem_rd_en  = rd;
        mem_wr_en  = wr;
        mem_wr_blk = data;
        @(negedge clk);
        check_int("busy_on_accept", int'(mem_busy), 1);
        idx   = blk_of(addr);
        e.cyc = cyc + int'(LATENCY);
        if (wr) begin
            e.is_rd      = 1'b0;
            e.data       = '0;
            ref_mem[idx] = data;
        end else begin
            e.is_rd = 1'b1;
            e.data  = ref_mem.exists(idx) ? ref_mem[idx] : '0;
        end
        sb.push_back(e);
        if (glitch) begin
            mem_wr_en  = 1'b1;
            mem_addr   = g_addr;
            mem_wr_blk = rand_blk();
            @(negedge clk);
            mem_wr_en  = wr;
            mem_addr   = addr;
            mem_wr_blk = data;
        end
        n = 0;
        while (!mem_ready && n < int'(LATENCY) + 4) begin
            @(negedge clk);
            n++;
        end
        if (!mem_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready still 0, want 1");
        end
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = $urandom;
        mem_wr_blk = rand_blk();
        @(negedge clk);
        check_int("busy_after_done", int'(mem_busy), 0);
        check_int("ready_after_done", int'(mem_ready), 0);
    endtask

    task automatic wr_blk(logic [PA_WIDTH-1:0] addr, blk_t data);
        issue(1'b0, 1'b1, addr, data, 1'b0, '0);
    endtask

    task automatic rd_blk(logic [PA_WIDTH-1:0] addr);
        issue(1'b1, 1'b0, addr, '0, 1'b0, '0);
    endtask

    initial begin
        blk_t          a5;
        blk_t          d;
        logic [31:0]   r;
        logic [31:0]   addr;
        int            idx;

        for (int i = 0; i < 64; i++) a5[i*8 +: 8] = 8'hA5;

        // Reset with random inputs toggling
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_addr   = $urandom;
            r          = $urandom;
            mem_rd_en  = r[0];
            mem_wr_en  = r[1];
            mem_wr_blk = rand_blk();
            @(negedge clk);
            check_int("reset_ready", int'(mem_ready), 0);
            check_int("reset_busy", int'(mem_busy), 0);
            check_blk("reset_rd_blk", mem_rd_blk, '0);
        end
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Write then read the same block via a different offset
        wr_blk(32'h0000_1040, a5);
        rd_blk(32'h0000_107C);

        // Simultaneous enables: only the write is performed
        wr_blk(32'h0000_0140, '0);
        issue(1'b1, 1'b1, 32'h0000_0140, 512'h1, 1'b0, '0);
        rd_blk(32'h0000_0140);

        // A write pulsed while busy is ignored
        wr_blk(32'h0000_00C0, rand_blk());
        wr_blk(32'h0000_0080, rand_blk());
        issue(1'b1, 1'b0, 32'h0000_0080, '0, 1'b1, 32'h0000_00C0);
        rd_blk(32'h0000_00C0);

        // Address aliasing above the index bits
        wr_blk(32'h0001_0000, 512'hBEEF);
        rd_blk(32'h0000_0000);

        // Reset during a write aborts it; previous contents survive
        wr_blk(32'h0000_01C0, 512'h11);
        wait_idle();
        mem_addr   = 32'h0000_01C0;
        mem_wr_blk = 512'hFF;
        mem_wr_en  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        mem_wr_en = 1'b0;
        ref_rd    = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_int("midrst_busy", int'(mem_busy), 0);
            check_blk("midrst_rd_blk", mem_rd_blk, '0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < int'(LATENCY) + 2; i++) @(negedge clk);
        rd_blk(32'h0000_01C0);
        rd_blk(32'h0000_1040);

        // Random traffic over 16 blocks with random offset and alias bits
        for (int i = 0; i < 60; i++) begin
            r    = $urandom;
            idx  = int'($urandom_range(0, 15));
            addr = (r & 32'hFFFF_0000) | (32'(idx) * BLK_BYTES) | (r & 32'h0000_003F);
            d    = rand_blk();
            if (!ref_mem.exists(idx) || r[7:6] == 2'b00) begin
                issue(r[8], 1'b1, addr, d, 1'b0, '0);
            end else begin
                rd_blk(addr);
            end
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
